noc_rr_arbiter: RTL and testbench
=================================

// Module: noc_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the NoC's single main_ram port among NUM_PORTS requesters
//  (bit order: wr_port0, wr_port1, rd_port0..rd_port3).
//  Issues one-hot grants, holds each grant until the RAM sequencer reports completion,
//  supports locked bursts, and force-releases a grant that is held too long.
//  Sits between the port valid lines and the noc RAM sequencer, which muxes addr/data on grant.
// PARAMETERS
//  NUM_PORTS  6   number of requesters; bit i of req/grant = port i
//  ID_W       3   width of grant_id; 2**ID_W >= NUM_PORTS required
//  MAX_HOLD   15  cycles a grant may stay active without done before forced release; 0 disables
//  HOLD_W     4   width of hold counter; 2**HOLD_W > MAX_HOLD required
// PORTS
//  clk          in   1          clock, all state on rising edge
//  rst          in   1          asynchronous active-low reset (0 = reset)
//  req          in   NUM_PORTS  request per port, level, held until served
//  done         in   1          1-cycle pulse from RAM sequencer: granted transaction complete
//  lock         in   1          sampled with done: 1 = keep current grant for another transaction
//  grant        out  NUM_PORTS  one-hot grant, registered; all-zero when idle
//  grant_valid  out  1          1 while any grant bit is set
//  grant_id     out  ID_W       binary index of granted port; 0 when idle
//  timeout      out  1          1-cycle pulse on forced release
// BEHAVIOUR
//  Reset (rst=0, async): grant=0, grant_valid=0, grant_id=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
//  ptr = highest-priority index; search order ptr, ptr+1, ..., NUM_PORTS-1, 0, ..., ptr-1.
//  States:
//   IDLE  - if |req: grant the first requester in search order at next edge -> GRANT, hold_cnt=0.
//           else stay IDLE. Latency: req sampled at edge k, grant visible after edge k.
//   GRANT - grant/grant_id held stable. Priority per cycle, highest first:
//           a) done=1 & lock=1           -> stay GRANT, hold_cnt=0
//           b) done=1 & lock=0           -> grant=0 next edge, ptr=id+1 (wrap to 0 at NUM_PORTS), IDLE
//           c) req[id]=0 (requester quit)-> release as b), no timeout pulse
//           d) MAX_HOLD!=0 & hold_cnt==MAX_HOLD-1 -> release as b), timeout=1 for one cycle
//           e) otherwise hold_cnt+1 (saturating at 2**HOLD_W-1)
//  Grant gap: at least one cycle with grant=0 between any two grants (RAM sequencer returns to idle).
//  done while IDLE is ignored. done and the timeout condition in the same cycle: done wins, no pulse.
//  Released port is lowest priority on the next arbitration; no port waits more than
//  NUM_PORTS-1 grants while its req is held.
//  req bits >= NUM_PORTS do not exist; req changes while in GRANT do not affect the current grant.
//  Reset mid-grant: grant drops immediately (async); the in-flight RAM op is abandoned.
//  The sequencer must also reset.
//  grant is always one-hot or zero; grant_valid == |grant; grant_id matches the grant bit.
// TESTING
//  T1 reset: rst=0 with req=6'b111111 -> grant=0, grant_valid=0, grant_id=0, timeout=0 throughout.
//  T2 fairness: req=6'b111111, done pulsed 2 cycles after each grant, lock=0
//     -> grant_id 0,1,2,3,4,5,0, one zero cycle between grants.
//  T3 sparse: req=6'b000101, done each grant -> grant_id 0,2,0,2; never grants 1,3,4,5.
//  T4 timeout: MAX_HOLD=15, req[3] held, no done -> grant[3] high exactly 15 cycles,
//     timeout pulses once, grant=0; next grant goes to port 3 again only if no other req (ptr=4).
//  T5 lock: req=6'b000011, grant_id=1, three done pulses with lock=1 -> grant_id stays 1;
//     done with lock=0 -> release, next grant_id=0.
//  T6 reset mid-grant: grant[4]=1, pulse rst low -> grant=0 asynchronously;
//     after release, req=6'b110000 -> grant_id=4 (ptr=0).
//  All: assertions for one-hot grant, grant_valid==|grant, and the one-cycle gap between grants.

Source files
------------

// File: rtl/noc_rr_arbiter_if.sv
// Handshake bundle between the NoC requesters, the RAM sequencer and the
// round-robin arbiter. The arbiter takes the slave view; the driving side
// (requesters plus sequencer) takes the master view.
interface noc_rr_arbiter_if #(
    parameter int NUM_PORTS = 6,
    parameter int ID_W      = 3
);
    logic [NUM_PORTS-1:0] req;
    logic                 done;
    logic                 lock;
    logic [NUM_PORTS-1:0] grant;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic                 timeout;

    modport master (
        output req, done, lock,
        input  grant, grant_valid, grant_id, timeout
    );

    modport slave (
        input  req, done, lock,
        output grant, grant_valid, grant_id, timeout
    );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter sharing the single main_ram port among NUM_PORTS
// requesters. Grants are one-hot and registered, held until the sequencer
// reports done, optionally extended by lock, and force-released after
// MAX_HOLD cycles without done. A released port drops to lowest priority.
module noc_rr_arbiter #(
    parameter int NUM_PORTS = 6,
    parameter int ID_W      = 3,
    parameter int MAX_HOLD  = 15,
    parameter int HOLD_W    = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    noc_rr_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Last hold count before a forced release (unused when MAX_HOLD is 0)
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? {HOLD_W{1'b0}} : HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};
    localparam logic [ID_W:0]     PORTS_EXT = (ID_W + 1)'(NUM_PORTS);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_PORTS - 1);

    state_t               r_state;
    logic [ID_W-1:0]      r_ptr;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [NUM_PORTS-1:0] r_grant;
    logic                 r_grant_valid;
    logic [ID_W-1:0]      r_grant_id;
    logic                 r_timeout;

    state_t               w_state_nxt;
    logic [ID_W-1:0]      w_ptr_nxt;
    logic [HOLD_W-1:0]    w_hold_nxt;
    logic [NUM_PORTS-1:0] w_grant_nxt;
    logic [ID_W-1:0]      w_id_nxt;
    logic                 w_timeout_nxt;

    logic                 w_pick_found;
    logic [ID_W-1:0]      w_pick_id;
    logic [ID_W:0]        w_cand;
    logic [ID_W-1:0]      w_rel_ptr;

    // First requester in search order ptr, ptr+1, ..., wrapping at NUM_PORTS
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = {ID_W{1'b0}};
        w_cand       = {(ID_W + 1){1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_cand = {1'b0, r_ptr} + (ID_W + 1)'(i);
            if (w_cand >= PORTS_EXT) begin
                w_cand = w_cand - PORTS_EXT;
            end else begin
                w_cand = w_cand;
            end
            if (!w_pick_found && bus.req[w_cand[ID_W-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_id    = w_cand[ID_W-1:0];
            end else begin
                w_pick_found = w_pick_found;
            end
        end
    end

    // Priority pointer after a release: the port just served goes last
    always_comb begin
        if (r_grant_id == LAST_ID) begin
            w_rel_ptr = {ID_W{1'b0}};
        end else begin
            w_rel_ptr = r_grant_id + ID_W'(1);
        end
    end

    // Next-state and next-output decode for the IDLE/GRANT controller
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_grant_nxt   = r_grant;
        w_id_nxt      = r_grant_id;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // done is meaningless here; only requests start a grant
                if (w_pick_found) begin
                    w_state_nxt            = ST_GRANT;
                    w_grant_nxt            = {NUM_PORTS{1'b0}};
                    w_grant_nxt[w_pick_id] = 1'b1;
                    w_id_nxt               = w_pick_id;
                    w_hold_nxt             = {HOLD_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = {NUM_PORTS{1'b0}};
                    w_id_nxt    = {ID_W{1'b0}};
                end
            end
            ST_GRANT: begin
                if (bus.done && bus.lock) begin
                    // locked burst: same owner, fresh hold window
                    w_hold_nxt = {HOLD_W{1'b0}};
                end else if (bus.done || !bus.req[r_grant_id] ||
                             ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST))) begin
                    // done beats the timeout; a quitting requester is released silently
                    w_state_nxt   = ST_IDLE;
                    w_grant_nxt   = {NUM_PORTS{1'b0}};
                    w_id_nxt      = {ID_W{1'b0}};
                    w_ptr_nxt     = w_rel_ptr;
                    w_hold_nxt    = {HOLD_W{1'b0}};
                    w_timeout_nxt = !bus.done && bus.req[r_grant_id];
                end else if (r_hold_cnt != HOLD_SAT) begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end else begin
                    w_hold_nxt = r_hold_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = {NUM_PORTS{1'b0}};
                w_id_nxt    = {ID_W{1'b0}};
                w_hold_nxt  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs; reset drops the grant without waiting for a clock
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= {ID_W{1'b0}};
            r_hold_cnt    <= {HOLD_W{1'b0}};
            r_grant       <= {NUM_PORTS{1'b0}};
            r_grant_valid <= 1'b0;
            r_grant_id    <= {ID_W{1'b0}};
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= |w_grant_nxt;
            r_grant_id    <= w_id_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;
    assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Bench for noc_rr_arbiter: directed scenarios plus a randomized run, all
// compared each cycle against a behavioural round-robin model.
module tb_noc_rr_arbiter;

    localparam int N    = 6;
    localparam int IDW  = 3;
    localparam int MAXH = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    noc_rr_arbiter_if #(.NUM_PORTS(N), .ID_W(IDW)) bus ();

    noc_rr_arbiter #(
        .NUM_PORTS(N), .ID_W(IDW), .MAX_HOLD(MAXH), .HOLD_W(4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_busy, m_id, m_ptr, m_hold, m_to, m_new;
    int age;
    logic [N-1:0] prev_g;
    int seen[$];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_id = 0; m_ptr = 0; m_hold = 0; m_to = 0; m_new = 0; age = 0;
    endtask

    // one clock edge of the arbitration rules
    task automatic model_edge(input logic [N-1:0] rq, input logic dn, input logic lk);
        m_to  = 0;
        m_new = 0;
        if (m_busy == 0) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (rq[p]) begin
                    m_busy = 1; m_id = p; m_hold = 0; m_new = 1;
                    break;
                end
            end
        end else if (dn && lk) begin
            m_hold = 0;
        end else if (dn || !rq[m_id] || (m_hold == MAXH - 1)) begin
            m_to   = (!dn && rq[m_id]) ? 1 : 0;
            m_busy = 0;
            m_ptr  = (m_id + 1) % N;
        end else begin
            m_hold = (m_hold >= 15) ? 15 : m_hold + 1;
        end
    endtask

    task automatic check_outputs();
        int exp_g;
        exp_g = m_busy ? (1 << m_id) : 0;
        chk_eq("grant", 32'(bus.grant), exp_g);
        chk_eq("grant_valid", 32'(bus.grant_valid), m_busy);
        chk_eq("grant_id", 32'(bus.grant_id), m_busy ? m_id : 0);
        chk_eq("timeout", 32'(bus.timeout), m_to);
        chk_eq("onehot", 32'($countones(bus.grant) <= 1), 1);
        chk_eq("valid_or", 32'(bus.grant_valid == (|bus.grant)), 1);
        chk_eq("gap", 32'((prev_g != '0) && (bus.grant != '0) && (bus.grant != prev_g)), 0);
        if (prev_g == '0 && bus.grant != '0) seen.push_back(int'(bus.grant_id));
        prev_g = bus.grant;
    endtask

    task automatic cyc(input logic [N-1:0] rq, input logic dn, input logic lk);
        bus.req  = rq;
        bus.done = dn;
        bus.lock = lk;
        @(posedge clk);
        if (rst) model_edge(rq, dn, lk);
        if (m_new != 0) age = 1;
        else if (m_busy != 0) age++;
        else age = 0;
        @(negedge clk);
        check_outputs();
    endtask

    // requester set held; sequencer answers dly cycles into each grant
    task automatic serve(input logic [N-1:0] rq, input int dly, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            cyc(rq, (m_busy != 0) && (age == dly), 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        bus.req  = 6'b111111;
        bus.done = 1'b0;
        bus.lock = 1'b0;
        model_reset();
        prev_g = '0;
        repeat (3) begin
            @(negedge clk);
            check_outputs();
        end
        rst = 1'b1;
        seen.delete();
    endtask

    initial begin
        int t2_exp[7];
        int t3_exp[4];
        int hi, tp, bad;
        logic [N-1:0] rq;
        int dp;
        t2_exp = '{0, 1, 2, 3, 4, 5, 0};
        t3_exp = '{0, 2, 0, 2};
        bus.req = '0; bus.done = 1'b0; bus.lock = 1'b0;
        prev_g = '0;
        model_reset();

        // T1 reset with all requests up
        do_reset();

        // T2 fairness
        serve(6'b111111, 2, 22);
        chk_eq("t2_count", 32'(seen.size() >= 7), 1);
        for (int k = 0; k < 7; k++)
            chk_eq("t2_order", (k < seen.size()) ? seen[k] : -1, t2_exp[k]);

        // T3 sparse
        do_reset();
        serve(6'b000101, 2, 13);
        chk_eq("t3_count", 32'(seen.size() >= 4), 1);
        for (int k = 0; k < 4; k++)
            chk_eq("t3_order", (k < seen.size()) ? seen[k] : -1, t3_exp[k]);
        bad = 0;
        foreach (seen[k]) if (seen[k] != 0 && seen[k] != 2) bad++;
        chk_eq("t3_only02", bad, 0);

        // T4 forced release, then port 0 wins from ptr=4
        do_reset();
        hi = 0; tp = 0;
        cyc(6'b001000, 1'b0, 1'b0);
        if (bus.grant[3]) hi++;
        for (int i = 0; i < 20; i++) begin
            cyc(6'b001001, 1'b0, 1'b0);
            if (bus.grant[3]) hi++;
            if (bus.timeout) tp++;
        end
        chk_eq("t4_hold", hi, 15);
        chk_eq("t4_pulses", tp, 1);
        chk_eq("t4_next", (seen.size() >= 2) ? seen[1] : -1, 0);

        // T5 locked burst
        do_reset();
        cyc(6'b000011, 1'b0, 1'b0);
        cyc(6'b000011, 1'b1, 1'b0);
        cyc(6'b000011, 1'b0, 1'b0);
        chk_eq("t5_first", 32'(bus.grant_id), 1);
        repeat (3) begin
            cyc(6'b000011, 1'b0, 1'b0);
            cyc(6'b000011, 1'b1, 1'b1);
        end
        chk_eq("t5_locked", 32'(bus.grant_id), 1);
        cyc(6'b000011, 1'b0, 1'b0);
        cyc(6'b000011, 1'b1, 1'b0);
        chk_eq("t5_release", 32'(bus.grant), 0);
        cyc(6'b000011, 1'b0, 1'b0);
        chk_eq("t5_next", 32'(bus.grant_id), 0);

        // T6 reset mid-grant
        do_reset();
        cyc(6'b010000, 1'b0, 1'b0);
        cyc(6'b010000, 1'b0, 1'b0);
        chk_eq("t6_held", 32'(bus.grant), 32'h10);
        #2 rst = 1'b0;
        #1;
        chk_eq("t6_async_grant", 32'(bus.grant), 0);
        chk_eq("t6_async_valid", 32'(bus.grant_valid), 0);
        model_reset();
        prev_g = '0;
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        cyc(6'b110000, 1'b0, 1'b0);
        chk_eq("t6_regrant", 32'(bus.grant_id), 4);

        // randomized traffic
        do_reset();
        rq = 6'(($urandom() & 32'h3F));
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) rq[$urandom_range(0, N - 1)] ^= 1'b1;
            dp = (((c / 500) % 2) != 0) ? 30 : 4;
            cyc(rq, $urandom_range(0, dp - 1) == 0, $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
